// File: rtl/fib_gals_tx.sv
// -----------------------------------------------------------------------------
// fib_gals_tx
//
// Producer side of a GALS link, clocked by clock_1. Words from the fibonacci
// generator are buffered in a small FIFO and handed to the clock_2 consumer one
// at a time over a four-phase req/ack handshake. The generator is throttled
// through f_en so that the FIFO never has to drop a word in normal use.
//
// Ports:
//   clock_1   in        producer clock
//   reset     in        asynchronous, active-high; clears all control state
//   f_valid   in        generator word valid this cycle
//   f_data    in  WIDTH generator word
//   f_en      out       generator enable (combinational)
//   ack       in        consumer acknowledge, asynchronous to clock_1
//   req       out       transfer request (registered)
//   data_out  out WIDTH transfer data (registered, stable while req=1)
//   count     out CW    FIFO occupancy, 0..DEPTH
//   empty     out       count == 0
//   full      out       count == DEPTH
//   overflow  out       sticky; set when a write had to be dropped
// -----------------------------------------------------------------------------
module fib_gals_tx #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock_1,
    input  logic             reset,
    input  logic             f_valid,
    input  logic [WIDTH-1:0] f_data,
    output logic             f_en,
    input  logic             ack,
    output logic             req,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic             ack_s1_q, ack_s_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Throttle ignores pops: a word requested now is guaranteed a free slot
    // when it arrives one cycle later, whatever the handshake does meanwhile.
    assign f_en = ({1'b0, count_q} + (CW+1)'(f_valid)) < (CW+1)'(DEPTH);

    // A push into a full FIFO is still accepted when the head leaves on the
    // same edge; the write lands on the slot being vacated.
    assign push = f_valid && ((count_q < DEPTH_C) || pop);
    assign drop = f_valid && !push;

    // Handshake FSM, next state and outputs.
    // NOTE: every signal gets its default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_out_d = data_out_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A consumer still holding ack from a previous transfer (or
                // asserting it early) blocks a new request.
                if (!empty && !ack_s_q) begin
                    pop        = 1'b1;
                    data_out_d = mem_q[rd_ptr_q];
                    req_d      = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind count, so clearing it would buy nothing.
    always_ff @(posedge clock_1) begin
        if (push) begin
            mem_q[wr_ptr_q] <= f_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, e.g. the two-flop ack synchroniser.
    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            ack_s1_q   <= 1'b0;
            ack_s_q    <= 1'b0;
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            data_out_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ack_s1_q   <= ack;
            ack_s_q    <= ack_s1_q;
            state_q    <= state_d;
            req_q      <= req_d;
            data_out_q <= data_out_d;
            count_q    <= count_d;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign req      = req_q;
    assign data_out = data_out_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fib_gals_tx.sv
// -----------------------------------------------------------------------------
// tb_fib_gals_tx
//
// Bench for fib_gals_tx. A generator model answers f_en with fibonacci words
// one cycle later and records each word in an expected-order queue; a clock_2
// consumer model answers req with ack two clock_2 cycles later and compares
// every delivered word against that queue. Directed steps cover reset, a
// stalled consumer, forced overflow, stuck ack timing and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_fib_gals_tx;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock_1 = 1'b0;
    logic             clock_2 = 1'b0;
    logic             reset   = 1'b0;
    logic             f_valid = 1'b0;
    logic [WIDTH-1:0] f_data  = '0;
    logic             f_en;
    logic             ack;
    logic             req;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;

    // ack comes from the consumer model when it is enabled, otherwise from
    // the directed steps.
    logic man_ack  = 1'b0;
    logic cons_on  = 1'b0;
    logic cons_ack = 1'b0;
    assign ack = cons_on ? cons_ack : man_ack;

    int vectors     = 0;
    int miscompares = 0;
    int c2_half     = 36;

    // Generator model state and scoreboard.
    logic [WIDTH-1:0] exp_q [$];
    int unsigned      fib_a = 0;
    int unsigned      fib_b = 1;
    int               gen_cnt = 0;
    int               gen_limit = 0;
    bit               gen_on = 1'b0;
    bit               gen_pend = 1'b0;
    bit               gen_jitter = 1'b0;
    int               recv_cnt = 0;
    logic [WIDTH-1:0] first_word = '0;
    logic [WIDTH-1:0] last_word = '0;

    fib_gals_tx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock_1  (clock_1),
        .reset    (reset),
        .f_valid  (f_valid),
        .f_data   (f_data),
        .f_en     (f_en),
        .ack      (ack),
        .req      (req),
        .data_out (data_out),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    // clock_1 edges fall on even times; clock_2 edges always on odd times,
    // so the two domains never share an instant.
    always #50 clock_1 = ~clock_1;

    initial begin
        #3;
        forever #(c2_half) clock_2 = ~clock_2;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock_1 cycle of the generator model: a word is presented in the
    // cycle after an edge that saw f_en high.
    task automatic tick();
        int unsigned t;
        @(negedge clock_1);
        f_valid = gen_pend;
        if (gen_pend) begin
            f_data = WIDTH'(fib_a);
            exp_q.push_back(WIDTH'(fib_a));
            t     = fib_a + fib_b;
            fib_a = fib_b;
            fib_b = t;
            gen_cnt++;
        end else begin
            f_data = WIDTH'($urandom);
        end
        #2;
        gen_pend = gen_on && f_en && (gen_cnt < gen_limit)
                   && !(gen_jitter && ($urandom_range(3) == 0));
    endtask

    task automatic do_reset();
        @(negedge clock_1);
        #4;
        cons_on  = 1'b0;
        gen_on   = 1'b0;
        gen_pend = 1'b0;
        man_ack  = 1'($urandom_range(1));
        f_valid  = 1'($urandom_range(1));
        f_data   = WIDTH'($urandom);
        reset    = 1'b1;
        #2;
        check("rst_req", req, 0);
        check("rst_data_out", data_out, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        f_valid = 1'b0;
        #2;
        check("rst_f_en", f_en, 1);
        man_ack    = 1'b0;
        exp_q.delete();
        fib_a      = 0;
        fib_b      = 1;
        gen_cnt    = 0;
        recv_cnt   = 0;
        first_word = '0;
        last_word  = '0;
        gen_jitter = 1'b0;
        repeat (2) @(posedge clock_1);
        @(negedge clock_1);
        reset = 1'b0;
    endtask

    task automatic run_until_received(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while ((recv_cnt < n || req || !empty) && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_in_time"}, 32'(i < budget), 1);
    endtask

    // Consumer model in the clock_2 domain: ack follows req after two
    // clock_2 cycles in each direction.
    initial begin : consumer
        int               wait_cnt;
        bit               held_valid;
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] exp_w;
        wait_cnt   = 0;
        held_valid = 1'b0;
        held       = '0;
        forever begin
            @(posedge clock_2);
            if (!cons_on) begin
                cons_ack   = 1'b0;
                wait_cnt   = 0;
                held_valid = 1'b0;
            end else begin
                if (req) begin
                    if (held_valid) begin
                        check("data_stable", data_out, held);
                    end
                    held       = data_out;
                    held_valid = 1'b1;
                end else begin
                    held_valid = 1'b0;
                end
                if (req != cons_ack) begin
                    wait_cnt++;
                    if (wait_cnt == 2) begin
                        wait_cnt = 0;
                        if (req) begin
                            check("word_expected", 32'(exp_q.size() != 0), 1);
                            if (exp_q.size() != 0) begin
                                exp_w = exp_q.pop_front();
                                check("word", data_out, exp_w);
                            end
                            recv_cnt++;
                            if (recv_cnt == 1) begin
                                first_word = data_out;
                            end
                            last_word = data_out;
                        end
                        cons_ack = req;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin : main
        int i;

        // Reset with arbitrary inputs.
        do_reset();

        // Stalled consumer: first request follows the first write by one
        // edge, then the FIFO fills and the generator is throttled.
        gen_limit = 1000;
        gen_on    = 1'b1;
        i = 0;
        while (empty && i < 10) begin
            tick();
            i++;
        end
        check("stall_first_write", empty, 0);
        check("stall_req_after_write", req, 0);
        tick();
        check("stall_req_rise", req, 1);
        check("stall_first_data", data_out, 0);
        repeat (18) tick();
        check("stall_req", req, 1);
        check("stall_data_out", data_out, 0);
        check("stall_count", count, DEPTH);
        check("stall_full", full, 1);
        check("stall_f_en", f_en, 0);
        check("stall_overflow", overflow, 0);
        check("stall_words_taken", exp_q.size(), DEPTH + 1);

        // Forced overflow: a word pushed into a full FIFO with no pop.
        gen_on = 1'b0;
        tick();
        @(negedge clock_1);
        f_valid = 1'b1;
        f_data  = 16'hBEEF;
        @(negedge clock_1);
        f_valid = 1'b0;
        #2;
        check("ovf_overflow", overflow, 1);
        check("ovf_count", count, DEPTH);
        check("ovf_req", req, 1);
        check("ovf_data_out", data_out, 0);
        // Draining must yield exactly 0,1,1,2,3 with no trace of the drop.
        c2_half = 2 * $urandom_range(10, 24);
        cons_on = 1'b1;
        run_until_received(DEPTH + 1, 500, "ovf_drain");
        check("ovf_drain_count", recv_cnt, DEPTH + 1);
        check("ovf_drain_last", last_word, 3);
        check("ovf_sticky", overflow, 1);
        check("ovf_queue_empty", exp_q.size(), 0);

        // Streaming, fast consumer clock.
        do_reset();
        c2_half   = 2 * $urandom_range(10, 24);
        gen_limit = 21;
        gen_on    = 1'b1;
        cons_on   = 1'b1;
        run_until_received(21, 3000, "fast_stream");
        check("fast_recv", recv_cnt, 21);
        check("fast_first", first_word, 0);
        check("fast_last", last_word, 6765);
        check("fast_queue_empty", exp_q.size(), 0);

        // Streaming, slow consumer clock, generator with random gaps.
        do_reset();
        c2_half    = 2 * $urandom_range(30, 60);
        gen_limit  = 21;
        gen_jitter = 1'b1;
        gen_on     = 1'b1;
        cons_on    = 1'b1;
        run_until_received(21, 3000, "slow_stream");
        check("slow_recv", recv_cnt, 21);
        check("slow_first", first_word, 0);
        check("slow_last", last_word, 6765);
        check("slow_queue_empty", exp_q.size(), 0);

        // Early/stuck ack: no request while ack is held high.
        do_reset();
        man_ack   = 1'b1;
        gen_limit = 5;
        gen_on    = 1'b1;
        repeat (12) tick();
        check("stuck_req", req, 0);
        check("stuck_count", count, DEPTH);
        check("stuck_overflow", overflow, 0);
        man_ack = 1'b0;
        tick();
        check("stuck_drop_e1", req, 0);
        tick();
        check("stuck_drop_e2", req, 0);
        tick();
        check("stuck_drop_e3", req, 1);
        check("stuck_data0", data_out, 0);

        // ack rise: req falls on the third edge.
        man_ack = 1'b1;
        tick();
        check("ack_rise_e1", req, 1);
        tick();
        check("ack_rise_e2", req, 1);
        tick();
        check("ack_rise_e3", req, 0);

        // ack fall: back to IDLE on the third edge, next req on the fourth.
        man_ack = 1'b0;
        tick();
        check("ack_fall_e1", req, 0);
        tick();
        check("ack_fall_e2", req, 0);
        tick();
        check("ack_fall_e3", req, 0);
        tick();
        check("ack_fall_e4", req, 1);
        check("ack_fall_data1", data_out, 1);
        check("mid_count", count, 3);

        // Reset in the middle of the REQ phase, then restart from 0.
        do_reset();
        c2_half   = 2 * $urandom_range(10, 60);
        gen_limit = 6;
        gen_on    = 1'b1;
        cons_on   = 1'b1;
        run_until_received(6, 1500, "restart");
        check("restart_recv", recv_cnt, 6);
        check("restart_first", first_word, 0);
        check("restart_last", last_word, 5);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
